// File: rtl/ysyx_22050243_dmem_resp_pkg.sv
// Shared widths, FSM encoding and byte-merge helper for the data-memory responder.
package ysyx_22050243_dmem_resp_pkg;

  localparam int unsigned DMEM_ADDR_W = 64;
  localparam int unsigned DMEM_DATA_W = 64;
  localparam int unsigned DMEM_MASK_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dmem_state_e;

  // Bytes whose enable bit is set come from new_word, the rest from old_word.
  function automatic logic [DMEM_DATA_W-1:0] be_merge(
    input logic [DMEM_DATA_W-1:0] old_word,
    input logic [DMEM_DATA_W-1:0] new_word,
    input logic [DMEM_MASK_W-1:0] be
  );
    logic [DMEM_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(DMEM_MASK_W); i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/ysyx_22050243_dmem_resp_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface ysyx_22050243_dmem_resp_if;
  import ysyx_22050243_dmem_resp_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [DMEM_ADDR_W-1:0] req_addr;
  logic [DMEM_DATA_W-1:0] req_wdata;
  logic [DMEM_MASK_W-1:0] req_wmask;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DMEM_DATA_W-1:0] resp_rdata;
  logic                   resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/ysyx_22050243_dmem_array.sv
// Single-port doubleword storage: byte-enable write, registered read, no reset.
module ysyx_22050243_dmem_array
  import ysyx_22050243_dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk_i,
  input  logic                   en_i,
  input  logic                   we_i,
  input  logic [DMEM_MASK_W-1:0] be_i,
  input  logic [IdxW-1:0]        idx_i,
  input  logic [DMEM_DATA_W-1:0] wdata_i,
  output logic [DMEM_DATA_W-1:0] rdata_o
);

  logic [DMEM_DATA_W-1:0] mem_q [DEPTH];
  logic [DMEM_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= be_merge(mem_q[idx_i], wdata_i, be_i);
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_22050243_dmem_resp.sv
// Data-memory responder: one outstanding aligned-doubleword request, fixed response latency.
module ysyx_22050243_dmem_resp
  import ysyx_22050243_dmem_resp_pkg::*;
#(
  parameter logic [DMEM_ADDR_W-1:0] BASE    = 64'h8000_0000,
  parameter int unsigned            DEPTH   = 4096,
  parameter int unsigned            LATENCY = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  ysyx_22050243_dmem_resp_if.slave   dmem_io
);

  localparam int unsigned            IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DMEM_ADDR_W-1:0] Span  = DMEM_ADDR_W'(DEPTH) * 64'd8;
  localparam logic [3:0]             LatM1 = 4'(LATENCY - 1);

  dmem_state_e            state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;
  logic                   rd_ok_q, rd_ok_d;
  logic                   wr_q;
  logic [DMEM_ADDR_W-1:0] addr_q;
  logic [DMEM_DATA_W-1:0] wdata_q;
  logic [DMEM_MASK_W-1:0] wmask_q;

  logic                   accept;
  logic                   enter_resp;
  logic                   leave_resp;
  logic                   acc_write;
  logic [DMEM_ADDR_W-1:0] acc_addr;
  logic [DMEM_DATA_W-1:0] acc_wdata;
  logic [DMEM_MASK_W-1:0] acc_wmask;
  logic [DMEM_ADDR_W-1:0] acc_off;
  logic                   in_range;
  logic [DMEM_DATA_W-1:0] arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dmem_io.req_valid && ready_q) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatM1;
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (dmem_io.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_d == StResp) && (state_q != StResp);
  assign leave_resp = (state_q == StResp) && (state_d == StIdle);

  // With LATENCY==1 the access happens on the accept edge, before the latch is loaded.
  always_comb begin
    if (state_q == StIdle) begin
      acc_write = dmem_io.req_write;
      acc_addr  = dmem_io.req_addr;
      acc_wdata = dmem_io.req_wdata;
      acc_wmask = dmem_io.req_wmask;
    end else begin
      acc_write = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
    end
  end

  assign acc_off  = acc_addr - BASE;
  assign in_range = (acc_addr >= BASE) && (acc_off < Span);

  always_comb begin
    err_d   = err_q;
    rd_ok_d = rd_ok_q;
    if (enter_resp) begin
      err_d   = !in_range;
      rd_ok_d = in_range && !acc_write;
    end else if (leave_resp) begin
      err_d   = 1'b0;
      rd_ok_d = 1'b0;
    end
  end

  assign ready_d = (state_d == StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
      if (accept) begin
        wr_q    <= dmem_io.req_write;
        addr_q  <= dmem_io.req_addr;
        wdata_q <= dmem_io.req_wdata;
        wmask_q <= dmem_io.req_wmask;
      end
    end
  end

  ysyx_22050243_dmem_array #(
    .DEPTH (DEPTH),
    .IdxW  (IdxW)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (enter_resp && in_range),
    .we_i    (acc_write),
    .be_i    (acc_wmask),
    .idx_i   (acc_off[IdxW+2:3]),
    .wdata_i (acc_wdata),
    .rdata_o (arr_rdata)
  );

  assign dmem_io.req_ready  = ready_q;
  assign dmem_io.resp_valid = (state_q == StResp);
  assign dmem_io.resp_err   = err_q;
  assign dmem_io.resp_rdata = rd_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_ysyx_22050243_dmem_resp.sv
// Bench for the data-memory responder: three latency builds against a word-map reference model.
module tb_ysyx_22050243_dmem_resp;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        resp_ready = 1'b0;
  logic [2:0]  req_valid = '0;
  wire  [2:0]  req_ready, resp_valid, resp_err;
  wire  [63:0] rdata0, rdata1, rdata2;

  int checks = 0;
  int errors = 0;
  logic [63:0] mdl [longint];

  always #5 clk = ~clk;

  ysyx_22050243_dmem_resp_if bus0 ();
  ysyx_22050243_dmem_resp_if bus1 ();
  ysyx_22050243_dmem_resp_if bus2 ();

  assign bus0.req_valid = req_valid[0];
  assign bus1.req_valid = req_valid[1];
  assign bus2.req_valid = req_valid[2];
  assign bus0.req_write = req_write;
  assign bus1.req_write = req_write;
  assign bus2.req_write = req_write;
  assign bus0.req_addr = req_addr;
  assign bus1.req_addr = req_addr;
  assign bus2.req_addr = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;
  assign bus0.req_wmask = req_wmask;
  assign bus1.req_wmask = req_wmask;
  assign bus2.req_wmask = req_wmask;
  assign bus0.resp_ready = resp_ready;
  assign bus1.resp_ready = resp_ready;
  assign bus2.resp_ready = resp_ready;
  assign req_ready  = {bus2.req_ready, bus1.req_ready, bus0.req_ready};
  assign resp_valid = {bus2.resp_valid, bus1.resp_valid, bus0.resp_valid};
  assign resp_err   = {bus2.resp_err, bus1.resp_err, bus0.resp_err};
  assign rdata0 = bus0.resp_rdata;
  assign rdata1 = bus1.resp_rdata;
  assign rdata2 = bus2.resp_rdata;

  ysyx_22050243_dmem_resp #(.BASE(BASE), .DEPTH(4096), .LATENCY(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .dmem_io(bus0)
  );
  ysyx_22050243_dmem_resp #(.BASE(BASE), .DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .dmem_io(bus1)
  );
  ysyx_22050243_dmem_resp #(.BASE(BASE), .DEPTH(64), .LATENCY(7)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .dmem_io(bus2)
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 7;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 4096 : 64;
  endfunction

  function automatic logic [63:0] rd_of(input int d);
    return (d == 0) ? rdata0 : (d == 1) ? rdata1 : rdata2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction: issue, time the response, check it, optionally stall, then handshake.
  task automatic txn(input int d, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                     input logic [7:0] m, input int hold);
    bit          exp_err;
    bit          known;
    logic [63:0] exp_rd;
    logic [63:0] old;
    logic [63:0] r0;
    logic        e0;
    longint      key;
    int          n;
    exp_err = !((a >= BASE) && (a < BASE + 64'd8 * 64'(depth_of(d))));
    key     = (longint'(d) << 40) + longint'((a - BASE) >> 3);
    known   = 1'b1;
    exp_rd  = '0;
    if (!wr && !exp_err) begin
      known = mdl.exists(key);
      if (known) exp_rd = mdl[key];
    end
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = wd; req_wmask = m;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {63'd0, req_ready[d]}, 64'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    if (wr && !exp_err) begin
      if (mdl.exists(key)) begin
        old = mdl[key];
        for (int b = 0; b < 8; b++) if (m[b]) old[8*b +: 8] = wd[8*b +: 8];
        mdl[key] = old;
      end else if (m == 8'hFF) begin
        mdl[key] = wd;
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid[d] !== 1'b1 && n < 40);
    chk("latency", 64'(n), 64'(lat_of(d)));
    chk("resp_err", {63'd0, resp_err[d]}, {63'd0, exp_err});
    if (known) chk("resp_rdata", rd_of(d), exp_rd);
    chk("busy_ready", {63'd0, req_ready[d]}, 64'd0);
    r0 = rd_of(d);
    e0 = resp_err[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, resp_valid[d]}, 64'd1);
      chk("hold_rdata", rd_of(d), r0);
      chk("hold_err", {63'd0, resp_err[d]}, {63'd0, e0});
      chk("hold_ready", {63'd0, req_ready[d]}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready", {63'd0, req_ready[d]}, 64'd1);
    chk("idle_valid", {63'd0, resp_valid[d]}, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] w;
    int          idx;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {61'd0, resp_valid}, 64'd0);
    chk("rst_err", {61'd0, resp_err}, 64'd0);
    chk("rst_rdata", rdata0, 64'd0);
    chk("rst_ready", {61'd0, req_ready}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", {61'd0, req_ready}, 64'd7);

    // Full store, load back, masked store, load back
    txn(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0);
    txn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0);
    txn(0, 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0C, 0);
    txn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0);
    chk("masked_model", mdl[64'h2], 64'h1122_3344_AAAA_7788);

    // Range errors; out-of-range stores must not disturb word 0
    txn(0, 1'b1, BASE, 64'hCAFE_F00D_1234_5678, 8'hFF, 0);
    txn(0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 0);
    txn(0, 1'b0, BASE + 64'd8 * 64'd4096, 64'h0, 8'h00, 0);
    txn(0, 1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    txn(0, 1'b1, BASE + 64'd8 * 64'd4096, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    txn(0, 1'b0, BASE, 64'h0, 8'h00, 0);

    // Zero-mask store is a no-op with a normal response; then a 5-cycle stall
    txn(0, 1'b1, 64'h8000_0010, 64'h0, 8'h00, 0);
    txn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 5);

    // LATENCY 1 and 7 builds, sub-word address bits ignored
    txn(1, 1'b1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    txn(1, 1'b0, 64'h8000_0025, 64'h0, 8'h00, 2);
    txn(2, 1'b1, 64'h8000_0020, 64'hFEDC_BA98_7654_3210, 8'hFF, 0);
    txn(2, 1'b0, 64'h8000_0025, 64'h0, 8'h00, 2);

    // Reset during WAIT of a store drops it
    @(negedge clk);
    req_write = 1'b1; req_addr = 64'h8000_0010; req_wdata = 64'h5555_5555_5555_5555;
    req_wmask = 8'hFF; req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_valid", {63'd0, resp_valid[0]}, 64'd0);
    chk("rst_wait_ready", {63'd0, req_ready[0]}, 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold_ready", {63'd0, req_ready[0]}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rel_ready", {63'd0, req_ready[0]}, 64'd1);
    txn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0);

    // Randomized traffic over a small window of words
    for (int i = 0; i < 16; i++) begin
      txn(0, 1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 0);
    end
    for (int i = 0; i < 40; i++) begin
      idx = int'($urandom_range(0, 15));
      a   = BASE + 64'(8 * idx) + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? BASE - 64'd8 * 64'($urandom_range(1, 4))
                                        : BASE + 64'd8 * 64'(4096 + $urandom_range(0, 3));
      end
      w = {$urandom, $urandom};
      txn(0, 1'($urandom_range(0, 1)), a, w, 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
